rv32i_mul_shift_unit: RTL

Parametrised multicycle shift unit for the execute stage. It implements SLL, SRL and SRA by issuing chunked multiplications by 2^r to a shared external multiplier IP, followed by a wired chunk realignment. It generalises data width and multiplier chunk width, and adds valid/ready handshakes, result backpressure, flush and variable-latency multiplier support. It sits between the execute-stage dispatch and the shared multiplier arbiter port.

---
 rtl/rv32i_mul_shift_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rv32i_mul_shift_unit.sv
// Multicycle SLL/SRL/SRA: the operand is multiplied chunk-by-chunk by 2^r and the chunks are realigned by wiring.
// Build option MULSHIFT_ZERO_BYPASS_EN: requests with r == 0 skip the multiplier and load the accumulator directly.
//   state  | meaning
//   IDLE   | waiting for a request, o_ready high
//   MUL    | one multiplier transaction per chunk, idx selects the chunk
//   FIN    | realign accumulator by q chunks, register o_result
//   DONE   | o_valid high until the consumer takes the result
module rv32i_mul_shift_unit #(
  parameter int XLEN  = 32,
  parameter int MUL_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [1:0]               i_op,
  input  logic [XLEN-1:0]          i_operand,
  input  logic [$clog2(XLEN)-1:0]  i_shamt,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_result,
  output logic                     o_mul_req,
  output logic [MUL_W-1:0]         o_mul_a,
  output logic [MUL_W-1:0]         o_mul_b,
  input  logic                     i_mul_valid,
  input  logic [2*MUL_W-1:0]       i_mul_result
);
  localparam int N     = XLEN / MUL_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int T_W   = $clog2(XLEN + 1);
  localparam int Q_W   = $clog2(N + 1);
  localparam int R_W   = $clog2(MUL_W);
  localparam int ACC_W = XLEN + MUL_W;
  localparam int P_W   = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic [R_W-1:0]   r_q, r_d;
  logic             inv_q, inv_d;
  logic             sll_q, sll_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             is_sll, neg_sra;
  logic [XLEN-1:0]  a_in;
  logic [T_W-1:0]   t_c;
  logic [Q_W-1:0]   q_c;
  logic [R_W-1:0]   r_c;
  logic [P_W-1:0]   p_c;
  logic [XLEN-1:0]  fin_c;
  logic [MUL_W-1:0] chunk_c;

  // Right shifts become a left shift by XLEN-shamt whose upper half is the answer;
  // negative SRA operands are inverted so the vacated bits fill with ones after re-inversion.
  always_comb begin
    is_sll  = (i_op == 2'b00);
    neg_sra = (i_op == 2'b10) && i_operand[XLEN-1];
    a_in    = neg_sra ? ~i_operand : i_operand;
    t_c     = is_sll ? T_W'(i_shamt) : (T_W'(XLEN) - T_W'(i_shamt));
    q_c     = Q_W'(t_c / T_W'(MUL_W));
    r_c     = R_W'(t_c % T_W'(MUL_W));
    p_c     = P_W'(acc_q) << (q_q * MUL_W);
    fin_c   = sll_q ? p_c[XLEN-1:0] : (p_c[P_W-1:XLEN] ^ {XLEN{inv_q}});
  end

  always_comb begin
    chunk_c = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) chunk_c = a_q[k*MUL_W +: MUL_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    q_d      = q_q;
    r_d      = r_q;
    inv_d    = inv_q;
    sll_d    = sll_q;
    result_d = result_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            a_d     = a_in;
            sll_d   = is_sll;
            inv_d   = neg_sra;
            q_d     = q_c;
            r_d     = r_c;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_MUL;
`ifdef MULSHIFT_ZERO_BYPASS_EN
            if (r_c == '0) begin
              acc_d   = ACC_W'(a_in);
              state_d = S_FIN;
            end
`endif
          end
        end
        S_MUL: begin
          // Partial products never overlap, so OR-ing them in is an exact sum.
          if (i_mul_valid) begin
            acc_d = acc_q | (ACC_W'(i_mul_result) << (idx_q * MUL_W));
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(N - 1)) state_d = S_FIN;
          end
        end
        S_FIN: begin
          result_d = fin_c;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      inv_q    <= 1'b0;
      sll_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      r_q      <= r_d;
      inv_q    <= inv_d;
      sll_q    <= sll_d;
      result_q <= result_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = (state_q == S_DONE);
  assign o_mul_req = (state_q == S_MUL);
  assign o_mul_a   = o_mul_req ? chunk_c : '0;
  assign o_mul_b   = o_mul_req ? (MUL_W'(1) << r_q) : '0;
  assign o_result  = result_q;

endmodule
